imm_gen_pipe: RTL and testbench
===============================

# imm_gen_pipe

Pipelined, parametrised immediate generator for the RISC-V decode path. It accepts a raw 32-bit instruction over a valid/ready handshake and decodes the immediate format from the opcode. It produces the sign- or zero-extended immediate at DATA_WIDTH, along with a format tag and an illegal flag. A 2-entry skid buffer registers both directions, so `in_ready` has no combinational path from `out_ready`. It sits between fetch and the register-read/ALU-operand stage.

## Interface
- DATA_WIDTH, 32: immediate output width; legal values are 32 or 64.
- ZEXT_LOGIC, 0: when 1, ANDI/ORI/XORI (opcode 0010011, funct3 111/110/100) zero-extend their immediate; when 0, they sign-extend (standard).

Ports:
- clk  in  1  sole clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  `instr` is valid this cycle.
- in_ready  out  1  block can accept; registered.
- instr  in  32  raw instruction.
- out_valid  out  1  head entry is valid.
- out_ready  in  1  consumer accepts the head entry.
- imm  out  DATA_WIDTH  extended immediate of the head entry.
- imm_fmt  out  3  `imm_fmt_t` of the head entry.
- illegal  out  1  the head opcode has no immediate format.

## Operation
- Decode uses opcode = instr[6:0]:
  - I format: 0010011, 0000011, 1100111. The imm is sext(instr[31:20]).
  - I_SHAMT format: opcode 0010011 with funct3 001/101. The imm is zext(instr[24:20]) at DATA_WIDTH=32, and zext(instr[25:20]) at 64.
  - S format: 0100011. The imm is sext({instr[31:25], instr[11:7]}).
  - B format: 1100011. The imm is sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
  - U format: 0110111, 0010111. The imm is sext({instr[31:12], 12'b0}); bits above 31 are copies of instr[31].
  - J format: 1101111. The imm is sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
  - Any other opcode: fmt=NONE, imm=0, illegal=1.
- ZEXT_LOGIC=1 applies only to the I-format logical ops; it does not affect ADDI, SLTI or SLTIU.
- Transfers:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
- The skid FSM tracks occupancy:
  - EMPTY: a push moves to ONE.
  - ONE: push only moves to TWO; pop only moves to EMPTY; push and pop together stay in ONE (head is replaced by the new entry).
  - TWO: in_ready=0, so no push can occur; a pop moves to ONE and the second entry becomes the head.
- in_ready is registered and equals (next_state != TWO).
- Each entry stores the already-decoded {imm, fmt, illegal}; decode runs before the buffer.

## Timing
- Reset values: state=EMPTY, out_valid=0, in_ready=1, imm=0, imm_fmt=NONE, illegal=0.
- Latency: an input accepted in cycle N is visible on the outputs in cycle N+1 when the buffer was empty.
- Throughput is 1 per cycle while out_ready=1.
- While out_valid && !out_ready, imm, imm_fmt and illegal are held stable.
- in_valid with in_ready=0 is ignored; the source must hold `instr`.
- If rst is asserted mid-operation, both entries are discarded on the next edge, and the block returns to its reset values with no partial output.
- A second entry accepted while the head is stalled drains in order, with no loss or duplication.

## Structure
- Package `imm_gen_pkg` contains:
  - `imm_fmt_t` (3-bit enum): NONE=0, I=1, S=2, B=3, U=4, J=5, I_SHAMT=6.
  - Opcode localparams: OP_IMM, OP_LOAD, OP_JALR, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL.
  - Skid state enum: EMPTY, ONE, TWO.
- Sub-module `imm_decode` is purely combinational: instr → {imm, fmt, illegal}, parametrised by DATA_WIDTH and ZEXT_LOGIC.
- The top level instantiates `imm_decode` and implements the skid FSM plus the two entry registers.

## Test plan
- Basic formats, out_ready=1:
  - addi x1,x0,-1 (0xFFF00093) → one cycle later imm=0xFFFFFFFF, fmt=I.
  - sw x1,-4(x2) (0xFE112E23) → imm=0xFFFFFFFC, fmt=S.
- U and shift, DATA_WIDTH=64:
  - lui (0x123450B7) → imm=0x0000000012345000, fmt=U.
  - lui (0x800000B7) → imm=0xFFFFFFFF80000000, fmt=U.
  - slli x1,x1,31 (0x01F09093) → imm=31, fmt=I_SHAMT.
- Illegal opcode and ZEXT_LOGIC:
  - 0x0000007F → illegal=1, imm=0, fmt=NONE.
  - andi x1,x1,-1 (0xFFF0F093) → imm=0x00000FFF with ZEXT_LOGIC=1, and imm=0xFFFFFFFF with ZEXT_LOGIC=0.
- Backpressure:
  - Hold out_ready=0 and push 3 instructions.
  - Required: the first two are accepted, then in_ready=0 and the third is held off.
  - Required: the head output is stable throughout the stall.
  - Release out_ready → all 3 drain in order over 3 cycles with no gap.
- Reset mid-stream:
  - Assert rst with state TWO → the next cycle shows out_valid=0, in_ready=1, imm=0.
  - The following push produces only the new entry.

Source files
------------

// File: rtl/imm_gen_pkg.sv
// Shared types and opcode constants for the pipelined immediate generator.
package imm_gen_pkg;

    // Immediate format tag carried with every decoded entry.
    typedef enum logic [2:0] {
        NONE    = 3'd0,
        I       = 3'd1,
        S       = 3'd2,
        B       = 3'd3,
        U       = 3'd4,
        J       = 3'd5,
        I_SHAMT = 3'd6
    } imm_fmt_t;

    // Major opcodes (instr[6:0]) that carry an immediate.
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // Occupancy of the two-entry output skid buffer.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } skid_state_t;

    // SLLI / SRLI / SRAI encode a shift amount rather than a signed immediate.
    function automatic logic is_shift_op(input logic [2:0] funct3);
        return (funct3 == 3'b001) || (funct3 == 3'b101);
    endfunction

    // ANDI / ORI / XORI: the only ops affected by the zero-extend option.
    function automatic logic is_logic_op(input logic [2:0] funct3);
        return (funct3 == 3'b111) || (funct3 == 3'b110) || (funct3 == 3'b100);
    endfunction

endpackage

// File: rtl/imm_gen_pipe_decode.sv
// Purely combinational RISC-V immediate decoder: instr -> {imm, fmt, illegal}.
module imm_decode
    import imm_gen_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter bit ZEXT_LOGIC = 1'b0
) (
    input  logic [31:0]           instr,
    output logic [DATA_WIDTH-1:0] imm,
    output imm_fmt_t              fmt,
    output logic                  illegal
);

    // RV64 shifts take a 6-bit shamt, RV32 shifts a 5-bit one.
    localparam int SHAMT_W = (DATA_WIDTH == 64) ? 6 : 5;

    logic [6:0] opcode;
    logic [2:0] funct3;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];

    // Candidate immediates, each already extended to the output width.
    logic [DATA_WIDTH-1:0] imm_i_sext;
    logic [DATA_WIDTH-1:0] imm_i_zext;
    logic [DATA_WIDTH-1:0] imm_shamt;
    logic [DATA_WIDTH-1:0] imm_s;
    logic [DATA_WIDTH-1:0] imm_b;
    logic [DATA_WIDTH-1:0] imm_u;
    logic [DATA_WIDTH-1:0] imm_j;

    assign imm_i_sext = {{(DATA_WIDTH-12){instr[31]}}, instr[31:20]};
    assign imm_i_zext = {{(DATA_WIDTH-12){1'b0}}, instr[31:20]};
    assign imm_shamt  = {{(DATA_WIDTH-SHAMT_W){1'b0}}, instr[20 +: SHAMT_W]};
    assign imm_s      = {{(DATA_WIDTH-12){instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b      = {{(DATA_WIDTH-13){instr[31]}}, instr[31], instr[7],
                         instr[30:25], instr[11:8], 1'b0};
    // instr[31] supplies bit 31 and every bit above it.
    assign imm_u      = {{(DATA_WIDTH-31){instr[31]}}, instr[30:12], 12'b0};
    assign imm_j      = {{(DATA_WIDTH-21){instr[31]}}, instr[31], instr[19:12],
                         instr[20], instr[30:21], 1'b0};

    // Select format and immediate from the opcode; unknown opcodes flag illegal.
    always_comb begin
        imm     = '0;
        fmt     = NONE;
        illegal = 1'b0;
        case (opcode)
            OP_IMM: begin
                if (is_shift_op(funct3)) begin
                    fmt = I_SHAMT;
                    imm = imm_shamt;
                end else if (ZEXT_LOGIC && is_logic_op(funct3)) begin
                    fmt = I;
                    imm = imm_i_zext;
                end else begin
                    fmt = I;
                    imm = imm_i_sext;
                end
            end
            OP_LOAD, OP_JALR: begin
                fmt = I;
                imm = imm_i_sext;
            end
            OP_STORE: begin
                fmt = S;
                imm = imm_s;
            end
            OP_BRANCH: begin
                fmt = B;
                imm = imm_b;
            end
            OP_LUI, OP_AUIPC: begin
                fmt = U;
                imm = imm_u;
            end
            OP_JAL: begin
                fmt = J;
                imm = imm_j;
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// Immediate generator: decode in front of a 2-entry skid buffer so that both
// the output data and in_ready come straight from flops.
module imm_gen_pipe
    import imm_gen_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter bit ZEXT_LOGIC = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           instr,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] imm,
    output imm_fmt_t              imm_fmt,
    output logic                  illegal
);

    logic [DATA_WIDTH-1:0] dec_imm;
    imm_fmt_t              dec_fmt;
    logic                  dec_illegal;

    imm_decode #(
        .DATA_WIDTH (DATA_WIDTH),
        .ZEXT_LOGIC (ZEXT_LOGIC)
    ) u_decode (
        .instr   (instr),
        .imm     (dec_imm),
        .fmt     (dec_fmt),
        .illegal (dec_illegal)
    );

    skid_state_t           state_reg;
    skid_state_t           state_next;
    logic                  in_ready_reg;

    logic [DATA_WIDTH-1:0] head_imm_reg;
    imm_fmt_t              head_fmt_reg;
    logic                  head_illegal_reg;
    logic [DATA_WIDTH-1:0] tail_imm_reg;
    imm_fmt_t              tail_fmt_reg;
    logic                  tail_illegal_reg;

    logic push;
    logic pop;
    logic head_from_dec;
    logic head_from_tail;
    logic tail_from_dec;

    assign out_valid = (state_reg != EMPTY);
    assign in_ready  = in_ready_reg;
    assign push      = in_valid && in_ready_reg;
    assign pop       = out_valid && out_ready;

    // Occupancy next-state and entry load selects.
    always_comb begin
        state_next     = state_reg;
        head_from_dec  = 1'b0;
        head_from_tail = 1'b0;
        tail_from_dec  = 1'b0;
        case (state_reg)
            EMPTY: begin
                if (push) begin
                    state_next    = ONE;
                    head_from_dec = 1'b1;
                end
            end
            ONE: begin
                if (push && pop) begin
                    head_from_dec = 1'b1;
                end else if (push) begin
                    state_next    = TWO;
                    tail_from_dec = 1'b1;
                end else if (pop) begin
                    state_next = EMPTY;
                end
            end
            TWO: begin
                // in_ready is low here, so only a pop can happen.
                if (pop) begin
                    state_next     = ONE;
                    head_from_tail = 1'b1;
                end
            end
            default: begin
                state_next = EMPTY;
            end
        endcase
    end

    // State register; in_ready is precomputed from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= EMPTY;
            in_ready_reg <= 1'b1;
        end else begin
            state_reg    <= state_next;
            in_ready_reg <= (state_next != TWO);
        end
    end

    // Head entry: fresh decode on push into an empty/draining slot, or tail promotion.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_imm_reg     <= '0;
            head_fmt_reg     <= NONE;
            head_illegal_reg <= 1'b0;
        end else if (head_from_dec) begin
            head_imm_reg     <= dec_imm;
            head_fmt_reg     <= dec_fmt;
            head_illegal_reg <= dec_illegal;
        end else if (head_from_tail) begin
            head_imm_reg     <= tail_imm_reg;
            head_fmt_reg     <= tail_fmt_reg;
            head_illegal_reg <= tail_illegal_reg;
        end
    end

    // Tail entry: captures a push that arrives while the head is stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            tail_imm_reg     <= '0;
            tail_fmt_reg     <= NONE;
            tail_illegal_reg <= 1'b0;
        end else if (tail_from_dec) begin
            tail_imm_reg     <= dec_imm;
            tail_fmt_reg     <= dec_fmt;
            tail_illegal_reg <= dec_illegal;
        end
    end

    assign imm     = head_imm_reg;
    assign imm_fmt = head_fmt_reg;
    assign illegal = head_illegal_reg;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Self-checking bench for imm_gen_pipe: vector table + scoreboard queue.
module tb_imm_gen_pipe;
    import imm_gen_pkg::*;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] imm32;   // DATA_WIDTH=32, ZEXT_LOGIC=0
        logic [31:0] imm32z;  // DATA_WIDTH=32, ZEXT_LOGIC=1
        logic [63:0] imm64;   // DATA_WIDTH=64, ZEXT_LOGIC=0
        imm_fmt_t    fmt;
        logic        illegal;
    } vec_t;

    localparam int NVEC = 15;

    vec_t vecs [NVEC];
    vec_t exp_q [$];
    vec_t cur_vec;
    vec_t mon_e;

    int total  = 0;
    int passed = 0;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] instr;
    logic        out_ready;

    logic        in_ready_a, out_valid_a, illegal_a;
    logic [31:0] imm_a;
    imm_fmt_t    fmt_a;
    logic        in_ready_z, out_valid_z, illegal_z;
    logic [31:0] imm_z;
    imm_fmt_t    fmt_z;
    logic        in_ready_w, out_valid_w, illegal_w;
    logic [63:0] imm_w;
    imm_fmt_t    fmt_w;

    always #5 clk = ~clk;

    imm_gen_pipe #(.DATA_WIDTH(32), .ZEXT_LOGIC(1'b0)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a), .instr(instr),
        .out_valid(out_valid_a), .out_ready(out_ready), .imm(imm_a), .imm_fmt(fmt_a),
        .illegal(illegal_a));

    imm_gen_pipe #(.DATA_WIDTH(32), .ZEXT_LOGIC(1'b1)) dut_zext (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_z), .instr(instr),
        .out_valid(out_valid_z), .out_ready(out_ready), .imm(imm_z), .imm_fmt(fmt_z),
        .illegal(illegal_z));

    imm_gen_pipe #(.DATA_WIDTH(64), .ZEXT_LOGIC(1'b0)) dut_w64 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w), .instr(instr),
        .out_valid(out_valid_w), .out_ready(out_ready), .imm(imm_w), .imm_fmt(fmt_w),
        .illegal(illegal_w));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
    endtask

    // Scoreboard: pop and compare on output transfer, push on input transfer.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else begin
            if (out_valid_a && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_output_queue_depth", 64'(exp_q.size()), 64'd1);
                end else begin
                    mon_e = exp_q.pop_front();
                    $display("out instr=%08h imm=%08h fmt=%0d illegal=%0b imm_zext=%08h imm64=%016h",
                             mon_e.instr, imm_a, fmt_a, illegal_a, imm_z, imm_w);
                    chk("imm32", 64'(imm_a), 64'(mon_e.imm32));
                    chk("fmt", 64'(fmt_a), 64'(mon_e.fmt));
                    chk("illegal", 64'(illegal_a), 64'(mon_e.illegal));
                    chk("imm32_zext", 64'(imm_z), 64'(mon_e.imm32z));
                    chk("imm64", imm_w, mon_e.imm64);
                    chk("fmt64", 64'(fmt_w), 64'(mon_e.fmt));
                    chk("valid64", 64'(out_valid_w), 64'd1);
                end
            end
            if (in_valid && in_ready_a) exp_q.push_back(cur_vec);
        end
    end

    // Present a vector and hold it until accepted (bounded).
    task automatic send(input vec_t v);
        bit accepted;
        accepted = 1'b0;
        cur_vec  = v;
        instr    = v.instr;
        in_valid = 1'b1;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (in_ready_a) begin
                accepted = 1'b1;
                break;
            end
            if (n >= 2) out_ready = 1'b1;
            @(posedge clk); #1;
        end
        chk("accept_timeout", 64'(accepted), 64'd1);
        @(posedge clk); #1;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int n = 0; n < 10; n++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk); #1;
        end
        chk("drain_left", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{32'hFFF00093, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFF_FFFFFFFF, I, 1'b0};
        vecs[1]  = '{32'hFE112E23, 32'hFFFFFFFC, 32'hFFFFFFFC, 64'hFFFFFFFF_FFFFFFFC, S, 1'b0};
        vecs[2]  = '{32'h123450B7, 32'h12345000, 32'h12345000, 64'h00000000_12345000, U, 1'b0};
        vecs[3]  = '{32'h800000B7, 32'h80000000, 32'h80000000, 64'hFFFFFFFF_80000000, U, 1'b0};
        vecs[4]  = '{32'h01F09093, 32'h0000001F, 32'h0000001F, 64'h00000000_0000001F, I_SHAMT, 1'b0};
        vecs[5]  = '{32'h0000007F, 32'h00000000, 32'h00000000, 64'h00000000_00000000, NONE, 1'b1};
        vecs[6]  = '{32'hFFF0F093, 32'hFFFFFFFF, 32'h00000FFF, 64'hFFFFFFFF_FFFFFFFF, I, 1'b0};
        vecs[7]  = '{32'hFE000EE3, 32'hFFFFFFFC, 32'hFFFFFFFC, 64'hFFFFFFFF_FFFFFFFC, B, 1'b0};
        vecs[8]  = '{32'h001000EF, 32'h00000800, 32'h00000800, 64'h00000000_00000800, J, 1'b0};
        vecs[9]  = '{32'h03F09093, 32'h0000001F, 32'h0000001F, 64'h00000000_0000003F, I_SHAMT, 1'b0};
        vecs[10] = '{32'h80012083, 32'hFFFFF800, 32'hFFFFF800, 64'hFFFFFFFF_FFFFF800, I, 1'b0};
        vecs[11] = '{32'h8000E093, 32'hFFFFF800, 32'h00000800, 64'hFFFFFFFF_FFFFF800, I, 1'b0};
        vecs[12] = '{32'hFFF0A093, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFF_FFFFFFFF, I, 1'b0};
        vecs[13] = '{32'hFFFFF097, 32'hFFFFF000, 32'hFFFFF000, 64'hFFFFFFFF_FFFFF000, U, 1'b0};
        vecs[14] = '{32'h00008067, 32'h00000000, 32'h00000000, 64'h00000000_00000000, I, 1'b0};

        rst       = 1'b1;
        in_valid  = 1'b0;
        instr     = 32'h0;
        out_ready = 1'b1;
        cur_vec   = vecs[0];

        // Reset values.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid_a), 64'd0);
        chk("rst_in_ready", 64'(in_ready_a), 64'd1);
        chk("rst_imm", 64'(imm_a), 64'd0);
        chk("rst_fmt", 64'(fmt_a), 64'(NONE));
        chk("rst_illegal", 64'(illegal_a), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Latency: accepted in cycle N, visible in cycle N+1.
        send(vecs[0]);
        in_valid = 1'b0;
        chk("latency_out_valid", 64'(out_valid_a), 64'd1);
        chk("latency_imm", 64'(imm_a), 64'(vecs[0].imm32));
        drain();

        // Pass 1: full throughput with out_ready=1.
        for (int i = 0; i < NVEC; i++) send(vecs[i]);
        drain();

        // Pass 2: random backpressure.
        for (int i = 0; i < NVEC; i++) begin
            out_ready = 1'($urandom_range(0, 1));
            send(vecs[NVEC-1-i]);
        end
        drain();

        // Backpressure: fill both entries, third is held off, then drain 3 in a row.
        @(posedge clk); #1;
        out_ready = 1'b0;
        cur_vec = vecs[0]; instr = vecs[0].instr; in_valid = 1'b1;
        @(negedge clk);
        chk("bp_ready_first", 64'(in_ready_a), 64'd1);
        @(posedge clk); #1;
        cur_vec = vecs[1]; instr = vecs[1].instr;
        @(negedge clk);
        chk("bp_ready_second", 64'(in_ready_a), 64'd1);
        chk("bp_head_second", 64'(imm_a), 64'(vecs[0].imm32));
        @(posedge clk); #1;
        cur_vec = vecs[7]; instr = vecs[7].instr;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_full_in_ready", 64'(in_ready_a), 64'd0);
            chk("bp_hold_imm", 64'(imm_a), 64'(vecs[0].imm32));
            chk("bp_hold_fmt", 64'(fmt_a), 64'(vecs[0].fmt));
            chk("bp_hold_valid", 64'(out_valid_a), 64'd1);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_drain_no_gap", 64'(out_valid_a), 64'd1);
            @(posedge clk); #1;
            if (k == 1) in_valid = 1'b0;
        end
        @(negedge clk);
        chk("bp_drained_valid", 64'(out_valid_a), 64'd0);
        chk("bp_queue_empty", 64'(exp_q.size()), 64'd0);

        // Reset with both entries occupied.
        @(posedge clk); #1;
        out_ready = 1'b0;
        cur_vec = vecs[2]; instr = vecs[2].instr; in_valid = 1'b1;
        @(posedge clk); #1;
        cur_vec = vecs[3]; instr = vecs[3].instr;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("mid_rst_full", 64'(in_ready_a), 64'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_out_valid", 64'(out_valid_a), 64'd0);
        chk("mid_rst_in_ready", 64'(in_ready_a), 64'd1);
        chk("mid_rst_imm", 64'(imm_a), 64'd0);
        chk("mid_rst_fmt", 64'(fmt_a), 64'(NONE));
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(vecs[8]);
        drain();
        repeat (4) @(posedge clk);
        #1;
        chk("post_rst_idle_valid", 64'(out_valid_a), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
